// File: rtl/fib_pkg.sv
// fib_pkg: shared checker state encoding and Fibonacci defaults for generator and checker
package fib_pkg;
    localparam int FIB_WIDTH = 8;
    localparam int FIB_F0 = 1;
    localparam int FIB_F1 = 1;
    typedef enum logic [1:0] {
        S_FIRST  = 2'd0,
        S_SECOND = 2'd1,
        S_TRACK  = 2'd2,
        S_ERR    = 2'd3
    } state_t;
endpackage

// File: rtl/fibonacci_checker.sv
// fibonacci_checker: validates a valid/ready stream of Fibonacci terms and latches the first mismatch
module fibonacci_checker
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH,
    parameter int F0 = FIB_F0,
    parameter int F1 = FIB_F1,
    parameter int CW = 16
) (
    input  logic             clk,
    input  logic             restart,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             term_ok,
    output logic [CW-1:0]    term_count,
    output logic             err,
    output logic [WIDTH-1:0] err_data,
    output logic [WIDTH-1:0] exp_data
);
    state_t           state;
    logic [WIDTH-1:0] prev1;
    logic [WIDTH-1:0] prev2;
    logic [WIDTH-1:0] expected;
    logic             accept;
    // Seeds first, then the wrapping recurrence; clear blocks the beat it coincides with
    always_comb begin
        expected = state == S_FIRST ? WIDTH'(F0) : state == S_SECOND ? WIDTH'(F1) : prev1 + prev2;
        in_ready = state != S_ERR && !clear;
        accept   = in_valid && in_ready;
    end
    // Checker FSM: advance history on a match, freeze the offending term on a mismatch
    always_ff @(posedge clk or posedge restart) begin
        if (restart) begin
            state      <= S_FIRST;
            prev1      <= '0;
            prev2      <= '0;
            term_ok    <= 1'b0;
            term_count <= '0;
            err        <= 1'b0;
            err_data   <= '0;
            exp_data   <= '0;
        end else if (clear) begin
            state      <= S_FIRST;
            prev1      <= '0;
            prev2      <= '0;
            term_ok    <= 1'b0;
            term_count <= '0;
            err        <= 1'b0;
            err_data   <= '0;
            exp_data   <= '0;
        end else begin
            term_ok <= 1'b0;
            if (accept && in_data == expected) begin
                term_ok    <= 1'b1;
                term_count <= &term_count ? term_count : term_count + 1'b1;
                prev2      <= prev1;
                prev1      <= in_data;
                state      <= state == S_FIRST ? S_SECOND : S_TRACK;
            end else if (accept) begin
                err      <= 1'b1;
                err_data <= in_data;
                exp_data <= expected;
                state    <= S_ERR;
            end
        end
    end
endmodule

// File: tb/tb_fibonacci_checker.sv
// tb_fibonacci_checker: scoreboard bench for the Fibonacci stream checker
module tb_fibonacci_checker;
    import fib_pkg::*;
    localparam int W = 8;
    localparam int CW = 4;

    typedef struct {
        logic ok;
        int   cnt;
        logic er;
        int   ed;
        int   xd;
    } exp_t;

    logic          clk = 1'b0;
    logic          restart = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic          term_ok;
    logic [CW-1:0] term_count;
    logic          err;
    logic [W-1:0]  err_data;
    logic [W-1:0]  exp_data;

    exp_t q[$];
    exp_t mon_e;
    logic mon_acc;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    fibonacci_checker #(.WIDTH(W), .F0(1), .F1(1), .CW(CW)) dut (
        .clk(clk),
        .restart(restart),
        .clear(clear),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .term_ok(term_ok),
        .term_count(term_count),
        .err(err),
        .err_data(err_data),
        .exp_data(exp_data)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    // Monitor: on every accepting edge pop one expectation, otherwise term_ok must stay low
    always @(posedge clk) begin
        mon_acc = in_valid && in_ready;
        #1;
        if (mon_acc) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_accept: got data %0d accepted, expected no accept at %0t", in_data, $time);
            end else begin
                mon_e = q.pop_front();
                chk("term_ok", term_ok, mon_e.ok);
                chk("term_count", term_count, mon_e.cnt);
                chk("err", err, mon_e.er);
                chk("err_data", err_data, mon_e.ed);
                chk("exp_data", exp_data, mon_e.xd);
            end
        end else begin
            chk("idle_term_ok", term_ok, 0);
        end
    end

    task automatic send(input int d, input logic ok, input int cnt, input int xd);
        logic got = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = W'(d);
        q.push_back('{ok, cnt, !ok, ok ? 0 : d, ok ? 0 : xd});
        #1 chk("in_ready_before_beat", in_ready, 1);
        repeat (8) begin
            @(posedge clk);
            if (in_valid && in_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("accept_within_budget", got, 1);
        if (!got) void'(q.pop_back());
    endtask

    task automatic good(input int d, input int cnt);
        send(d, 1'b1, cnt, 0);
    endtask

    task automatic bad(input int d, input int cnt, input int xd);
        send(d, 1'b0, cnt, xd);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic clr();
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        int seq[16] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121, 98, 219};
        repeat (2) @(negedge clk);
        chk("reset_term_ok", term_ok, 0);
        chk("reset_count", term_count, 0);
        chk("reset_err", err, 0);
        chk("reset_err_data", err_data, 0);
        chk("reset_exp_data", exp_data, 0);
        chk("reset_in_ready", in_ready, 1);
        restart = 1'b0;

        // Full run through the 8-bit wrap; the count saturates at 15 on the last term
        for (int i = 0; i < 16; i++) good(seq[i], i < 15 ? i + 1 : 15);
        idle(1);
        chk("wrap_err", err, 0);
        chk("sat_count", term_count, 15);

        // Mismatch 1,1,2,4 and the error state refusing further beats
        clr();
        chk("clear_count", term_count, 0);
        good(1, 1);
        good(1, 2);
        good(2, 3);
        bad(4, 3, 3);
        idle(1);
        chk("mm_err", err, 1);
        chk("mm_err_data", err_data, 4);
        chk("mm_exp_data", exp_data, 3);
        chk("mm_in_ready", in_ready, 0);
        in_valid = 1'b1;
        in_data  = 8'd5;
        repeat (2) @(negedge clk);
        chk("err_hold_in_ready", in_ready, 0);
        chk("err_hold_count", term_count, 3);

        // Clear with a live beat of 1: the beat is dropped
        in_data = 8'd1;
        clear   = 1'b1;
        #1 chk("clear_in_ready", in_ready, 0);
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("recover_err", err, 0);
        chk("recover_count", term_count, 0);
        chk("recover_err_data", err_data, 0);
        good(1, 1);
        good(1, 2);
        good(2, 3);
        idle(1);
        chk("recover_final_count", term_count, 3);

        // Bad first term, then a gapped stream
        clr();
        bad(0, 0, 1);
        idle(1);
        chk("bs_err", err, 1);
        chk("bs_err_data", err_data, 0);
        chk("bs_exp_data", exp_data, 1);
        clr();
        good(1, 1);
        idle(2);
        good(1, 2);
        idle(2);
        good(2, 3);
        idle(2);
        good(3, 4);
        idle(1);
        chk("gap_count", term_count, 4);
        chk("gap_err", err, 0);

        // Asynchronous restart between edges while term_ok is high
        clr();
        good(1, 1);
        good(1, 2);
        good(2, 3);
        #3;
        in_valid = 1'b0;
        restart  = 1'b1;
        #1;
        chk("async_count", term_count, 0);
        chk("async_term_ok", term_ok, 0);
        chk("async_err", err, 0);
        chk("async_state", dut.state, S_FIRST);
        chk("async_in_ready", in_ready, 1);
        @(negedge clk);
        restart = 1'b0;
        good(1, 1);
        good(1, 2);
        idle(1);
        chk("post_restart_count", term_count, 2);

        repeat (2) @(negedge clk);
        chk("scoreboard_drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
